// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int          DEF_ADDR_W      = 32;
    localparam int          DEF_INSTR_BYTES = 4;
    localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_e;

    // Source selected for the next PC
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_PEND   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Pipeline-side bus of the fetch sequencer: PC loop, imem handshake,
// hazard/redirect inputs and IF/ID, ID/EX control outputs.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] PCResult;
    logic [ADDR_W-1:0] Address;
    logic              imem_req;
    logic              imem_ack;
    logic              stall_id;
    logic              jump_id;
    logic [ADDR_W-1:0] jump_target_id;
    logic              br_taken_ex;
    logic [ADDR_W-1:0] br_target_ex;
    logic              fetch_valid;
    logic              ifid_write;
    logic              flush_if_id;
    logic              flush_id_ex;

    // Sequencer side
    modport master (
        input  PCResult, imem_ack, stall_id, jump_id, jump_target_id,
               br_taken_ex, br_target_ex,
        output Address, imem_req, fetch_valid, ifid_write,
               flush_if_id, flush_id_ex
    );

    // Datapath / memory side
    modport slave (
        output PCResult, imem_ack, stall_id, jump_id, jump_target_id,
               br_taken_ex, br_target_ex,
        input  Address, imem_req, fetch_valid, ifid_write,
               flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Next-PC selection: branch-over-jump priority, word alignment of redirect
// targets, and the hold / sequential / target / pending source mux.
module fetch_sequencer_next_pc_mux
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic [ADDR_W-1:0] pend_i,
    input  pc_sel_e           sel_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] target_o,
    output logic [ADDR_W-1:0] next_pc_o
);
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] seq_pc;

    // An EX branch is older than an ID jump, so it wins.
    assign redirect_o = br_taken_i | jump_i;
    assign raw_target = br_taken_i ? br_target_i : jump_target_i;
    assign target_o   = {raw_target[ADDR_W-1:2], 2'b00};
    // Wraps naturally at the top of the address space.
    assign seq_pc     = pc_i + ADDR_W'(INSTR_BYTES);

    // Pick the PC source requested by the FSM
    always_comb begin
        next_pc_o = pc_i;
        case (sel_i)
            SEL_SEQ:    next_pc_o = seq_pc;
            SEL_TARGET: next_pc_o = target_o;
            SEL_PEND:   next_pc_o = pend_i;
            default:    next_pc_o = pc_i;
        endcase
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM and next-PC controller. Issues imem requests at PCResult,
// steers the PC register, remembers redirects that land while an access is
// still in flight, and raises the IF/ID and ID/EX flushes.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                INSTR_BYTES = DEF_INSTR_BYTES
) (
    input logic               Clk,
    input logic               Reset,
    fetch_sequencer_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;

    pc_sel_e           pc_sel;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    logic              req_o, fetch_valid_o, flush_if_id_o, flush_id_ex_o;

    logic              ack;
    logic              stall;

    assign ack   = bus.imem_ack;
    assign stall = bus.stall_id;

    fetch_sequencer_next_pc_mux #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_pc_mux (
        .pc_i          (bus.PCResult),
        .jump_i        (bus.jump_id),
        .jump_target_i (bus.jump_target_id),
        .br_taken_i    (bus.br_taken_ex),
        .br_target_i   (bus.br_target_ex),
        .pend_i        (pend_q),
        .sel_i         (pc_sel),
        .redirect_o    (redirect),
        .target_o      (target),
        .next_pc_o     (next_pc)
    );

    // State and pending-redirect registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= BOOT;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Next-state logic; an access already issued must complete (DRAIN)
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        case (state_q)
            BOOT: state_d = FETCH;  // any stale ack here is ignored
            FETCH: begin
                if (redirect) begin
                    if (!ack) begin
                        state_d      = DRAIN;
                        pend_d       = target;
                        pend_valid_d = 1'b1;
                    end
                end else if (!stall && !ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (!ack) begin
                        state_d      = DRAIN;
                        pend_d       = target;
                        pend_valid_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (ack) begin
                    state_d = stall ? HOLD : FETCH;
                end
            end
            DRAIN: begin
                if (redirect) pend_d = target;
                if (ack) begin
                    state_d      = FETCH;
                    pend_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect || !stall) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    // Output logic: request, accept, flushes and PC source select
    always_comb begin
        req_o         = 1'b0;
        fetch_valid_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        pc_sel        = SEL_HOLD;
        if (!Reset) begin
            if (state_q != BOOT) begin
                flush_if_id_o = bus.br_taken_ex | bus.jump_id;
                flush_id_ex_o = bus.br_taken_ex;
            end
            case (state_q)
                FETCH: begin
                    req_o = !stall;
                    if (redirect) begin
                        if (ack) pc_sel = SEL_TARGET;
                    end else if (!stall && ack) begin
                        fetch_valid_o = 1'b1;
                        pc_sel        = SEL_SEQ;
                    end
                end
                WAIT: begin
                    req_o = 1'b1;
                    if (redirect) begin
                        if (ack) pc_sel = SEL_TARGET;
                    end else if (ack && !stall) begin
                        fetch_valid_o = 1'b1;
                        pc_sel        = SEL_SEQ;
                    end
                end
                DRAIN: begin
                    req_o = 1'b1;
                    if (ack) begin
                        if (redirect)          pc_sel = SEL_TARGET;
                        else if (pend_valid_q) pc_sel = SEL_PEND;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_sel = SEL_TARGET;
                    end else if (!stall) begin
                        fetch_valid_o = 1'b1;
                        pc_sel        = SEL_SEQ;
                    end
                end
                default: pc_sel = SEL_HOLD;
            endcase
        end
    end

    assign bus.Address     = Reset ? RESET_VEC : next_pc;
    assign bus.imem_req    = req_o;
    assign bus.fetch_valid = fetch_valid_o;
    assign bus.ifid_write  = fetch_valid_o;
    assign bus.flush_if_id = flush_if_id_o;
    assign bus.flush_id_ex = flush_id_ex_o;
endmodule
